// File: rtl/mdio_activity_watchdog.sv
// Multi-channel line-activity watchdog: per-line synchroniser, glitch filter and idle timer.
// Define MDIO_WDOG_IDLE_MAX_EN to add the per-channel idle_max high-water-mark output.
module mdio_activity_watchdog #(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = 31,
   parameter int FILT_LEN   = 2,
   parameter bit AUTO_REARM = 1'b1
) (
   input  logic                    clk_25m,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       sig_in,
   input  logic [NUM_CH-1:0]       wdog_en,
   input  logic [CNT_W-1:0]        timeout_val,
   input  logic [NUM_CH-1:0]       kick,
   input  logic [NUM_CH-1:0]       clr_sticky,
   output logic [NUM_CH-1:0]       time_out_pulse,
   output logic [NUM_CH-1:0]       time_out_sticky,
   output logic                    time_out_any,
   output logic [NUM_CH-1:0]       ch_busy
`ifdef MDIO_WDOG_IDLE_MAX_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] idle_max
`endif
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   // Hard ceiling so a timeout_val lowered below the running count cannot wrap the counter
   localparam logic [CNT_W-1:0] CNT_TOP  = {{(CNT_W-1){1'b1}}, 1'b0};
   localparam logic [3:0]       STAB_END = 4'(FILT_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   logic             tv_nonzero_s;
   logic [CNT_W-1:0] tv_last_s;
   logic             any_r;

   assign tv_nonzero_s = (timeout_val != CNT_ZERO);
   assign tv_last_s    = timeout_val - CNT_ONE;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic             sync1_r;
      logic             sync2_r;
      logic             filt_r;
      logic             filt_d_r;
      logic [3:0]       stab_r;
      state_t           state_r;
      state_t           state_nxt_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_nxt_s;
      logic             fire_s;
      logic             act_s;
      logic             enabled_s;
      logic             term_s;
      logic             pulse_r;
      logic             sticky_r;
      logic             busy_r;

      // Synchroniser and stable-count filter; a short excursion restarts the count
      always_ff @(posedge clk_25m or negedge rst_n) begin
         if (!rst_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            filt_r   <= 1'b0;
            filt_d_r <= 1'b0;
            stab_r   <= 4'd0;
         end else begin
            sync1_r  <= sig_in[g];
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            if (sync2_r != filt_r) begin
               if (stab_r == STAB_END) begin
                  filt_r <= sync2_r;
                  stab_r <= 4'd0;
               end else begin
                  stab_r <= stab_r + 4'd1;
               end
            end else begin
               stab_r <= 4'd0;
            end
         end
      end

      assign act_s     = (filt_r ^ filt_d_r) | kick[g];
      assign enabled_s = wdog_en[g] & tv_nonzero_s;
      assign term_s    = (cnt_r == tv_last_s) || (cnt_r == CNT_TOP);

      // Next-state and counter decode; activity outranks the terminal count
      always_comb begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
         fire_s      = 1'b0;
         if (!enabled_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_nxt_s = ST_ARMED;
                  cnt_nxt_s   = CNT_ZERO;
               end
               ST_ARMED: begin
                  if (act_s) begin
                     cnt_nxt_s = CNT_ZERO;
                  end else if (term_s) begin
                     fire_s      = 1'b1;
                     cnt_nxt_s   = CNT_ZERO;
                     state_nxt_s = AUTO_REARM ? ST_ARMED : ST_EXPIRED;
                  end else begin
                     cnt_nxt_s = cnt_r + CNT_ONE;
                  end
               end
               ST_EXPIRED: begin
                  cnt_nxt_s = CNT_ZERO;
                  if (act_s) begin
                     state_nxt_s = ST_ARMED;
                  end else begin
                     state_nxt_s = ST_EXPIRED;
                  end
               end
               default: begin
                  state_nxt_s = ST_IDLE;
                  cnt_nxt_s   = CNT_ZERO;
               end
            endcase
         end
      end

      // State, counter and per-channel output registers; a new timeout beats clr_sticky
      always_ff @(posedge clk_25m or negedge rst_n) begin
         if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            pulse_r  <= 1'b0;
            sticky_r <= 1'b0;
            busy_r   <= 1'b0;
         end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pulse_r <= fire_s;
            busy_r  <= (state_nxt_s == ST_ARMED);
            if (fire_s) begin
               sticky_r <= 1'b1;
            end else if (clr_sticky[g]) begin
               sticky_r <= 1'b0;
            end else begin
               sticky_r <= sticky_r;
            end
         end
      end

      assign time_out_pulse[g]  = pulse_r;
      assign time_out_sticky[g] = sticky_r;
      assign ch_busy[g]         = busy_r;

`ifdef MDIO_WDOG_IDLE_MAX_EN
      logic [CNT_W-1:0] max_r;

      // Longest idle stretch seen while armed, cleared together with the sticky flag
      always_ff @(posedge clk_25m or negedge rst_n) begin
         if (!rst_n) begin
            max_r <= CNT_ZERO;
         end else if (clr_sticky[g]) begin
            max_r <= CNT_ZERO;
         end else if ((state_r == ST_ARMED) && (cnt_r > max_r)) begin
            max_r <= cnt_r;
         end else begin
            max_r <= max_r;
         end
      end

      assign idle_max[g*CNT_W +: CNT_W] = max_r;
`else
      // No idle high-water mark in this build.
`endif
   end

   // Aggregate flag trails the sticky bits by one cycle
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         any_r <= 1'b0;
      end else begin
         any_r <= |time_out_sticky;
      end
   end

   assign time_out_any = any_r;

endmodule

// File: tb/tb_mdio_activity_watchdog.sv
// Self-checking bench for mdio_activity_watchdog: a timestamp-based model checked every cycle,
// one DUT with auto re-arm and one without, plus hand-computed directed expectations.
module tb_mdio_activity_watchdog;
   localparam int NUM_CH   = 2;
   localparam int CNT_W    = 31;
   localparam int FILT_LEN = 2;

   logic                clk_25m = 1'b0;
   logic                rst_n;
   logic [NUM_CH-1:0]   sig_in, wdog_en, kick, clr_sticky;
   logic [CNT_W-1:0]    timeout_val;
   logic [NUM_CH-1:0]   pulse_a, sticky_a, busy_a, pulse_b, sticky_b, busy_b;
   logic                any_a, any_b;
`ifdef MDIO_WDOG_IDLE_MAX_EN
   logic [NUM_CH*CNT_W-1:0] max_a, max_b;
`endif

   always #20 clk_25m = ~clk_25m;

   mdio_activity_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .AUTO_REARM(1'b1)) u_dut (
      .clk_25m(clk_25m), .rst_n(rst_n), .sig_in(sig_in), .wdog_en(wdog_en),
      .timeout_val(timeout_val), .kick(kick), .clr_sticky(clr_sticky),
      .time_out_pulse(pulse_a), .time_out_sticky(sticky_a), .time_out_any(any_a), .ch_busy(busy_a)
`ifdef MDIO_WDOG_IDLE_MAX_EN
      , .idle_max(max_a)
`endif
   );

   mdio_activity_watchdog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .AUTO_REARM(1'b0)) u_dut_hold (
      .clk_25m(clk_25m), .rst_n(rst_n), .sig_in(sig_in), .wdog_en(wdog_en),
      .timeout_val(timeout_val), .kick(kick), .clr_sticky(clr_sticky),
      .time_out_pulse(pulse_b), .time_out_sticky(sticky_b), .time_out_any(any_b), .ch_busy(busy_b)
`ifdef MDIO_WDOG_IDLE_MAX_EN
      , .idle_max(max_b)
`endif
   );

   int n_chk, n_pass, n_fail, edge_no;

   // Model: index 0 = auto re-arm instance, 1 = hold instance. Counting is by
   // timestamp: a timeout fires when timeout_val edges have elapsed since the last restart.
   int     cyc;
   int     hist [NUM_CH][FILT_LEN+2];
   int     m_filt [NUM_CH];
   bit     m_chg [NUM_CH];
   bit     m_run [2][NUM_CH];
   bit     m_exp [2][NUM_CH];
   int     m_start [2][NUM_CH];
   bit     e_pulse [2][NUM_CH];
   bit     e_sticky [2][NUM_CH];
   bit     e_any [2];
   longint e_max [2][NUM_CH];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   task automatic model_reset();
      cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_filt[c] = 0;
         m_chg[c]  = 1'b0;
         for (int k = 0; k < FILT_LEN+2; k++) hist[c][k] = 0;
         for (int i = 0; i < 2; i++) begin
            m_run[i][c] = 1'b0; m_exp[i][c] = 1'b0; m_start[i][c] = 0;
            e_pulse[i][c] = 1'b0; e_sticky[i][c] = 1'b0; e_max[i][c] = 0;
         end
      end
      e_any[0] = 1'b0;
      e_any[1] = 1'b0;
   endtask

   task automatic model_edge();
      bit     act, flip, en;
      longint age;
      if (!rst_n) begin
         model_reset();
         return;
      end
      cyc++;
      for (int i = 0; i < 2; i++) begin
         e_any[i] = 1'b0;
         for (int c = 0; c < NUM_CH; c++) if (e_sticky[i][c]) e_any[i] = 1'b1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = FILT_LEN+1; k > 0; k--) hist[c][k] = hist[c][k-1];
         hist[c][0] = int'(sig_in[c]);
         // the synchronised level is the sample from two edges back
         flip = 1'b1;
         for (int k = 2; k <= FILT_LEN+1; k++) if (hist[c][k] == m_filt[c]) flip = 1'b0;
         act = m_chg[c] || kick[c];
         m_chg[c] = flip;
         if (flip) m_filt[c] = 1 - m_filt[c];
         en = wdog_en[c] && (timeout_val != '0);
         for (int i = 0; i < 2; i++) begin
            age = longint'(cyc - 1 - m_start[i][c]);
            if (clr_sticky[c]) e_max[i][c] = 0;
            else if (m_run[i][c] && age > e_max[i][c]) e_max[i][c] = age;
            e_pulse[i][c] = 1'b0;
            if (!en) begin
               m_run[i][c] = 1'b0; m_exp[i][c] = 1'b0;
            end else if (m_run[i][c]) begin
               if (act) m_start[i][c] = cyc;
               else if (longint'(cyc - m_start[i][c]) == longint'(timeout_val)) begin
                  e_pulse[i][c] = 1'b1;
                  m_start[i][c] = cyc;
                  if (i == 1) begin m_run[i][c] = 1'b0; m_exp[i][c] = 1'b1; end
               end
            end else if (m_exp[i][c]) begin
               if (act) begin m_exp[i][c] = 1'b0; m_run[i][c] = 1'b1; m_start[i][c] = cyc; end
            end else begin
               m_run[i][c] = 1'b1; m_start[i][c] = cyc;
            end
            if (e_pulse[i][c]) e_sticky[i][c] = 1'b1;
            else if (clr_sticky[c]) e_sticky[i][c] = 1'b0;
         end
      end
   endtask

   task automatic compare();
      logic [NUM_CH-1:0] p, s, b;
      logic              a;
      for (int i = 0; i < 2; i++) begin
         p = (i == 0) ? pulse_a : pulse_b;
         s = (i == 0) ? sticky_a : sticky_b;
         b = (i == 0) ? busy_a : busy_b;
         a = (i == 0) ? any_a : any_b;
         chk($sformatf("any[%0d]", i), a, e_any[i]);
         for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("pulse[%0d][%0d]", i, c), p[c], e_pulse[i][c]);
            chk($sformatf("sticky[%0d][%0d]", i, c), s[c], e_sticky[i][c]);
            chk($sformatf("busy[%0d][%0d]", i, c), b[c], m_run[i][c]);
`ifdef MDIO_WDOG_IDLE_MAX_EN
            chk($sformatf("idle_max[%0d][%0d]", i, c),
                (i == 0) ? max_a[c*CNT_W +: CNT_W] : max_b[c*CNT_W +: CNT_W], e_max[i][c]);
`endif
         end
      end
   endtask

   task automatic step();
      @(posedge clk_25m);
      model_edge();
      @(negedge clk_25m);
      edge_no++;
      compare();
   endtask

   int t0, np, nb, n1, first, last;

   initial begin
      n_chk = 0; n_pass = 0; n_fail = 0; edge_no = 0;
      rst_n = 1'b0; sig_in = '0; wdog_en = '0; kick = '0; clr_sticky = '0;
      timeout_val = 31'd10;
      model_reset();
      step(); step();
      chk("rst_pulse", pulse_a, 0);
      chk("rst_sticky", sticky_a, 0);
      chk("rst_any", any_a, 0);
      chk("rst_busy", busy_a, 0);

      // Static lines, channel 0 enabled: pulse 10 edges after the arming edge
      rst_n = 1'b1; wdog_en = 2'b01;
      t0 = edge_no + 1; np = 0; n1 = 0; first = -1;
      repeat (15) begin
         step();
         if (pulse_a[0]) begin np++; if (first < 0) first = edge_no - t0; end
         if (pulse_a[1] || sticky_a[1] || busy_a[1]) n1++;
         if (edge_no == t0 + 10) begin
            chk("t1_sticky_with_pulse", sticky_a[0], 1);
            chk("t1_any_lags", any_a, 0);
         end
         if (edge_no == t0 + 11) chk("t1_any_set", any_a, 1);
      end
      chk("t1_first_pulse", first, 10);
      chk("t1_pulse_count", np, 1);
      chk("t1_ch1_quiet", n1, 0);
      chk("t1_hold_expired", busy_b[0], 0);

      // Level held 8 cycles between toggles: no timeout while toggling
      np = 0; last = 0;
      for (int n = 0; n < 26; n++) begin
         sig_in[0] = ~sig_in[0];
         last = edge_no;
         repeat (8) begin step(); if (pulse_a[0]) np++; end
      end
      chk("t2_no_pulse_toggling", np, 0);
      first = -1;
      while (edge_no < last + 20) begin
         step();
         if (pulse_a[0] && first < 0) first = edge_no - last;
      end
      chk("t2_pulse_after_stop", first, 15);

      // One-cycle glitches every 5 cycles are filtered out
      wdog_en[0] = 1'b0; step();
      wdog_en[0] = 1'b1;
      np = 0; nb = 0;
      for (int g = 0; g < 11; g++) begin
         sig_in[0] = 1'b1; step();
         if (pulse_a[0]) np++;
         if (pulse_b[0]) nb++;
         sig_in[0] = 1'b0;
         repeat (4) begin step(); if (pulse_a[0]) np++; if (pulse_b[0]) nb++; end
      end
      chk("t3_rearm_pulses", np, 5);
      chk("t3_hold_pulses", nb, 1);
      chk("t3_hold_not_busy", busy_b[0], 0);
      chk("t3_rearm_busy", busy_a[0], 1);

      // Kick on the terminal cycle suppresses the timeout; set beats clr_sticky
      wdog_en[0] = 1'b0; clr_sticky[0] = 1'b1; step();
      clr_sticky[0] = 1'b0; wdog_en[0] = 1'b1; t0 = edge_no + 1;
      chk("t4_sticky_cleared", sticky_a[0], 0);
      while (edge_no < t0 + 9) step();
      kick[0] = 1'b1; step(); kick[0] = 1'b0;
      chk("t4_kick_no_pulse", pulse_a[0], 0);
      chk("t4_kick_no_sticky", sticky_a[0], 0);
      while (edge_no < t0 + 19) step();
      clr_sticky[0] = 1'b1; step(); clr_sticky[0] = 1'b0;
      chk("t4_pulse_after_kick", pulse_a[0], 1);
      chk("t4_set_beats_clr", sticky_a[0], 1);

      // Disable at cnt=7, then asynchronous reset mid-count
      wdog_en[0] = 1'b0; step();
      wdog_en[0] = 1'b1; t0 = edge_no + 1;
      while (edge_no < t0 + 7) step();
      chk("t5_busy_before_drop", busy_a[0], 1);
      wdog_en[0] = 1'b0; step();
      chk("t5_idle_not_busy", busy_a[0], 0);
      chk("t5_sticky_kept", sticky_a[0], 1);
      wdog_en[0] = 1'b1;
      repeat (5) step();
      chk("t5_sticky_before_rst", sticky_a[0], 1);
      #7 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_rst_pulse", pulse_a, 0);
      chk("t5_rst_sticky", sticky_a, 0);
      chk("t5_rst_any", any_a, 0);
      chk("t5_rst_busy", busy_a, 0);
      step();
      rst_n = 1'b1;
      repeat (3) step();

`ifdef MDIO_WDOG_IDLE_MAX_EN
      // Idle gaps of 4 then 7 cycles leave a high-water mark of 6
      timeout_val = 31'd20; wdog_en[0] = 1'b0; clr_sticky[0] = 1'b1; step();
      clr_sticky[0] = 1'b0; wdog_en[0] = 1'b1; t0 = edge_no + 1;
      while (edge_no < t0 + 3) step();
      kick[0] = 1'b1; step(); kick[0] = 1'b0;
      while (edge_no < t0 + 10) step();
      kick[0] = 1'b1; step(); kick[0] = 1'b0;
      step();
      kick[0] = 1'b1; step(); kick[0] = 1'b0;
      wdog_en[0] = 1'b0;
      step(); step();
      chk("t6_idle_max", max_a[CNT_W-1:0], 6);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
